// File: rtl/servo_motion_sequencer.sv
// Frame-synchronous four-channel servo sequencer: once per frame it samples
// joystick positions, maps them to pulse widths and slews each output toward its target.
module servo_motion_sequencer #(
   parameter int FRAME_CYCLES = 500000,
   parameter int MIN_US       = 650,
   parameter int MAX_US       = 2600,
   parameter int CENTER_US    = 1500,
   parameter int STEP_US      = 20
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ENABLE,
   input  logic [3:0]  HOLD,
   input  logic [39:0] POS,
   output logic [11:0] PULSE_US0,
   output logic [11:0] PULSE_US1,
   output logic [11:0] PULSE_US2,
   output logic [11:0] PULSE_US3,
   output logic [3:0]  AT_TARGET,
   output logic        BUSY,
   output logic        FRAME_STROBE
);

   localparam int              CNT_W   = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [11:0]     SPAN    = 12'(MAX_US - MIN_US);
   localparam logic [11:0]     CENTER  = 12'(CENTER_US);

   typedef enum logic [2:0] {IDLE, LATCH, MAP, STEP, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  frame_cnt;
   logic              tick;
   logic [1:0]        idx;
   logic [9:0]        pos_sh [4];
   logic [11:0]       pulse  [4];
   logic [11:0]       target [4];

   // Linear position-to-width map; the 22-bit product is truncated, never rounded.
   function automatic logic [11:0] map_pos(input logic [9:0] pos);
      logic [21:0] prod;
      prod = 22'(pos) * 22'(SPAN);
      return 12'(MIN_US) + prod[21:10];
   endfunction

   // Move cur toward tgt by at most STEP_US; STEP_US of zero means jump straight there.
   function automatic logic [11:0] slew(input logic [11:0] cur, input logic [11:0] tgt);
      logic signed [12:0] d;
      logic signed [12:0] mag;
      logic signed [12:0] step;
      d    = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      mag  = (d < 0) ? -d : d;
      step = 13'(STEP_US);
      if (STEP_US == 0 || mag <= step)
         return tgt;
      else if (d > 0)
         return cur + 12'(STEP_US);
      else
         return cur - 12'(STEP_US);
   endfunction

   // Frame timebase runs independently of ENABLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_cnt <= '0;
         tick      <= 1'b0;
      end else begin
         tick      <= (frame_cnt == CNT_LAST);
         frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick && ENABLE) state_nxt = LATCH;
         LATCH:   state_nxt = MAP;
         MAP:     state_nxt = STEP;
         STEP:    state_nxt = (idx == 2'd3) ? DONE : MAP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Position shadow is pure data and needs no reset.
   always_ff @(posedge CLK) begin
      if (state == LATCH) begin
         for (int i = 0; i < 4; i++) pos_sh[i] <= POS[10*i +: 10];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            pulse[i]  <= CENTER;
            target[i] <= CENTER;
         end
      end else begin
         case (state)
            LATCH: idx <= 2'd0;
            MAP:   if (!HOLD[idx]) target[idx] <= map_pos(pos_sh[idx]);
            STEP: begin
               pulse[idx] <= slew(pulse[idx], target[idx]);
               if (idx != 2'd3) idx <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) AT_TARGET[i] = (pulse[i] == target[i]);
   end

   assign PULSE_US0    = pulse[0];
   assign PULSE_US1    = pulse[1];
   assign PULSE_US2    = pulse[2];
   assign PULSE_US3    = pulse[3];
   assign BUSY         = (state != IDLE);
   assign FRAME_STROBE = (state == DONE);

endmodule
